// File: rtl/hog_pkg.sv
// Shared constants for the HOG pipeline: stream widths and default detection-window size.
package hog_pkg;
  localparam int PIX_W        = 8;
  localparam int XB_W         = 32;
  localparam int PIX_PER_WORD = XB_W / PIX_W;
  localparam int WIN_W        = 64;
  localparam int WIN_H        = 128;

  typedef logic [$clog2(PIX_PER_WORD)-1:0] byte_idx_t;

  function automatic logic [PIX_W-1:0] sel_pix(input logic [XB_W-1:0] word, input byte_idx_t idx);
    return word[idx*PIX_W +: PIX_W];
  endfunction
endpackage

// File: rtl/hog_pixel_unpacker_if.sv
// Host word stream in, tagged pixel stream out. The master modport is the unpacker's view.
interface hog_pixel_unpacker_if;
  import hog_pkg::*;

  logic [XB_W-1:0]  from_host_pix_tdata;
  logic             from_host_pix_tvalid;
  logic             from_host_pix_tready;
  logic [PIX_W-1:0] pix_tdata;
  logic             pix_tvalid;
  logic             pix_tready;
  logic             pix_tuser;
  logic             pix_tlast;

  modport master (
    input  from_host_pix_tdata, from_host_pix_tvalid, pix_tready,
    output from_host_pix_tready, pix_tdata, pix_tvalid, pix_tuser, pix_tlast
  );

  modport slave (
    output from_host_pix_tdata, from_host_pix_tvalid, pix_tready,
    input  from_host_pix_tready, pix_tdata, pix_tvalid, pix_tuser, pix_tlast
  );
endinterface

// File: rtl/hog_frame_pos.sv
// Raster x/y position tracker advancing on en; flags start-of-frame, end-of-line, end-of-frame
// for the pixel currently presented (before the advance).
module hog_frame_pos #(
  parameter int W = 64,
  parameter int H = 128
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sof,
  output logic eol,
  output logic eof
);
  localparam int XW = (W > 1) ? $clog2(W) : 1;
  localparam int YW = (H > 1) ? $clog2(H) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(H - 1);

  logic [XW-1:0] x_d, x_q;
  logic [YW-1:0] y_d, y_q;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (en) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign sof = (x_q == '0) && (y_q == '0);
  assign eol = (x_q == X_LAST);
  assign eof = eol && (y_q == Y_LAST);
endmodule

// File: rtl/hog_pixel_unpacker.sv
// Splits 32-bit host words into four 8-bit pixels, one per cycle, tagged with SOF/EOL.
// A new word may load in the same cycle the last byte leaves, so a steady stream has no bubbles.
module hog_pixel_unpacker
  import hog_pkg::*;
#(
  parameter int IMG_WIDTH  = WIN_W,
  parameter int IMG_HEIGHT = WIN_H,
  parameter int CNT_W      = 16
) (
  input  logic               ap_clk,
  input  logic               quiesce,
  hog_pixel_unpacker_if.master bus,
  output logic               frame_done,
  output logic [CNT_W-1:0]   frame_count
);
  localparam byte_idx_t LAST_IDX = byte_idx_t'(PIX_PER_WORD - 1);

  logic [XB_W-1:0]  word_d, word_q;
  byte_idx_t        byte_idx_d, byte_idx_q;
  logic             full_d, full_q;
  logic             frame_done_d, frame_done_q;
  logic [CNT_W-1:0] frame_count_d, frame_count_q;

  logic out_fire, in_fire, in_rdy, last_byte;
  logic sof, eol, eof;

  assign last_byte = (byte_idx_q == LAST_IDX);
  assign out_fire  = full_q && bus.pix_tready;
  // Ready never looks at tvalid; quiesce masks it so nothing loads while in reset.
  assign in_rdy    = !quiesce && (!full_q || (bus.pix_tready && last_byte));
  assign in_fire   = bus.from_host_pix_tvalid && in_rdy;

  hog_frame_pos #(.W(IMG_WIDTH), .H(IMG_HEIGHT)) u_pos (
    .clk (ap_clk),
    .rst (quiesce),
    .en  (out_fire),
    .sof (sof),
    .eol (eol),
    .eof (eof)
  );

  always_comb begin
    word_d        = word_q;
    byte_idx_d    = byte_idx_q;
    full_d        = full_q;
    frame_done_d  = out_fire && eof;
    frame_count_d = frame_count_q + CNT_W'(frame_done_d);
    if (out_fire) begin
      if (last_byte) begin
        full_d     = 1'b0;
        byte_idx_d = '0;
      end else begin
        byte_idx_d = byte_idx_q + 1'b1;
      end
    end
    if (in_fire) begin
      word_d     = bus.from_host_pix_tdata;
      full_d     = 1'b1;
      byte_idx_d = '0;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (quiesce) begin
      word_q        <= '0;
      byte_idx_q    <= '0;
      full_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      word_q        <= word_d;
      byte_idx_q    <= byte_idx_d;
      full_q        <= full_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign bus.from_host_pix_tready = in_rdy;
  assign bus.pix_tvalid = full_q;
  assign bus.pix_tdata  = sel_pix(word_q, byte_idx_q);
  assign bus.pix_tuser  = full_q && sof;
  assign bus.pix_tlast  = full_q && eol;
  assign frame_done     = frame_done_q;
  assign frame_count    = frame_count_q;
endmodule

// File: tb/tb_hog_pixel_unpacker.sv
// Directed bench for hog_pixel_unpacker on a small 8x2 frame with a 2-bit frame counter.
module tb_hog_pixel_unpacker;
  localparam int W  = 8;
  localparam int H  = 2;
  localparam int CW = 2;
  localparam int FR = W * H;

  logic          ap_clk;
  logic          quiesce;
  logic          frame_done;
  logic [CW-1:0] frame_count;

  hog_pixel_unpacker_if bus_if ();

  hog_pixel_unpacker #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .CNT_W(CW)) dut (
    .ap_clk      (ap_clk),
    .quiesce     (quiesce),
    .bus         (bus_if),
    .frame_done  (frame_done),
    .frame_count (frame_count)
  );

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  int   pix_idx  = 0;
  int   exp_cnt  = 0;
  bit   exp_done = 0;
  logic [7:0] byte_ctr = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mkword(input logic [7:0] b);
    logic [7:0] b1, b2, b3;
    b1 = b + 8'd1;
    b2 = b + 8'd2;
    b3 = b + 8'd3;
    return {b3, b2, b1, b};
  endfunction

  task automatic check_outs();
    chk("frame_done", 32'(frame_done), 32'(exp_done));
    chk("frame_count", 32'(frame_count), 32'(exp_cnt % 4));
    exp_done = 0;
    if (bus_if.pix_tvalid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_vld", 32'(bus_if.pix_tvalid), 32'd0);
      end else begin
        chk("tdata", 32'(bus_if.pix_tdata), 32'(exp_q[0]));
        chk("tuser", 32'(bus_if.pix_tuser), 32'((pix_idx % FR) == 0));
        chk("tlast", 32'(bus_if.pix_tlast), 32'((pix_idx % W) == W - 1));
      end
    end else begin
      chk("tuser_idle", 32'(bus_if.pix_tuser), 32'd0);
      chk("tlast_idle", 32'(bus_if.pix_tlast), 32'd0);
    end
  endtask

  task automatic run(input int n_words, input int vpct, input int rpct, input int stop_pix, input bit cont);
    int sent = 0, fires = 0, cyc = 0;
    int first_in = -1, first_vld = -1, first_fire = -1, last_fire = -1;
    bit prev_stall = 0;
    logic [7:0] pd;
    logic pu, pl;
    while (1) begin
      @(negedge ap_clk);
      cyc++;
      check_outs();
      if (prev_stall) begin
        chk("stall_vld", 32'(bus_if.pix_tvalid), 32'd1);
        chk("stall_tdata", 32'(bus_if.pix_tdata), 32'(pd));
        chk("stall_tuser", 32'(bus_if.pix_tuser), 32'(pu));
        chk("stall_tlast", 32'(bus_if.pix_tlast), 32'(pl));
      end
      if (bus_if.pix_tvalid && first_vld < 0) first_vld = cyc;
      if (fires == stop_pix || (sent == n_words && exp_q.size() == 0)) break;
      if (cyc > 4000) begin
        chk("timeout", 32'(cyc), 32'd4000);
        break;
      end
      bus_if.from_host_pix_tvalid = (sent < n_words) && ($urandom_range(99) < vpct);
      bus_if.from_host_pix_tdata  = mkword(byte_ctr);
      bus_if.pix_tready           = ($urandom_range(99) < rpct);
      #1;
      if (bus_if.from_host_pix_tvalid && bus_if.from_host_pix_tready) begin
        for (int i = 0; i < 4; i++) exp_q.push_back(byte_ctr + 8'(i));
        byte_ctr = byte_ctr + 8'd4;
        sent++;
        if (first_in < 0) first_in = cyc;
      end
      if (bus_if.pix_tvalid && bus_if.pix_tready) begin
        void'(exp_q.pop_front());
        if ((pix_idx % FR) == FR - 1) begin
          exp_done = 1;
          exp_cnt++;
        end
        pix_idx++;
        fires++;
        if (first_fire < 0) first_fire = cyc;
        last_fire = cyc;
      end
      prev_stall = bus_if.pix_tvalid && !bus_if.pix_tready;
      pd = bus_if.pix_tdata;
      pu = bus_if.pix_tuser;
      pl = bus_if.pix_tlast;
    end
    bus_if.from_host_pix_tvalid = 1'b0;
    if (cont) begin
      chk("latency", 32'(first_vld - first_in), 32'd1);
      chk("no_bubble", 32'(last_fire - first_fire), 32'(fires - 1));
    end
  endtask

  task automatic do_reset();
    quiesce = 1'b1;
    bus_if.pix_tready = 1'b0;
    bus_if.from_host_pix_tvalid = 1'b0;
    repeat (3) begin
      @(negedge ap_clk);
      chk("rst_done", 32'(frame_done), 32'd0);
      chk("rst_tready", 32'(bus_if.from_host_pix_tready), 32'd0);
    end
    quiesce = 1'b0;
    #1;
    chk("rst_tvalid", 32'(bus_if.pix_tvalid), 32'd0);
    chk("rst_tdata", 32'(bus_if.pix_tdata), 32'd0);
    chk("rst_tuser", 32'(bus_if.pix_tuser), 32'd0);
    chk("rst_tlast", 32'(bus_if.pix_tlast), 32'd0);
    chk("rst_count", 32'(frame_count), 32'd0);
    chk("rst_tready_after", 32'(bus_if.from_host_pix_tready), 32'd1);
    exp_q.delete();
    pix_idx  = 0;
    exp_cnt  = 0;
    exp_done = 0;
  endtask

  initial begin
    quiesce = 1'b1;
    bus_if.from_host_pix_tdata  = '0;
    bus_if.from_host_pix_tvalid = 1'b0;
    bus_if.pix_tready           = 1'b0;
    do_reset();

    // One frame of 0x00..0x0F at full rate.
    run(4, 100, 100, -1, 1'b1);
    // Random downstream stalls over three frames (counter wraps 4 -> 0).
    run(12, 100, 50, -1, 1'b0);
    // Random input gaps over two frames.
    run(8, 40, 100, -1, 1'b0);
    // Reset after 37 pixels, then a fresh frame starts at (0,0).
    run(12, 100, 100, 37, 1'b0);
    do_reset();
    run(4, 100, 100, -1, 1'b1);
    // Five back-to-back frames with no bubble across frame boundaries.
    run(20, 100, 100, -1, 1'b1);
    chk("final_count", 32'(frame_count), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hog_pixel_unpacker.md
Name: hog_pixel_unpacker

Overview:
- Downstream consumer of a Xillybus host-to-FPGA 32-bit AXI-Stream (/dev/xillybus_pixels), clocked on ap_clk.
- Unpacks each 32-bit word into four 8-bit grayscale pixels and emits them one per cycle on an AXI-Stream pixel bus.
- Tags each pixel with start-of-frame and end-of-line flags for the HOG gradient stage.
- Frames are fixed-size detection windows; the block tracks x/y position and counts completed frames.

Parameters:
- IMG_WIDTH, 64, pixels per line; must be a multiple of 4 and at least 4.
- IMG_HEIGHT, 128, lines per frame; at least 1.
- CNT_W, 16, width of frame_count.

Ports:
- ap_clk  in  1  sole clock (Xillybus application clock).
- quiesce  in  1  synchronous reset, active-high.
- from_host_pix_tdata  in  32  packed pixels; byte 0 ([7:0]) is the leftmost pixel.
- from_host_pix_tvalid  in  1  input word valid.
- from_host_pix_tready  out  1  input word accepted when tvalid && tready.
- pix_tdata  out  8  pixel value.
- pix_tvalid  out  1  pixel valid.
- pix_tready  in  1  downstream ready.
- pix_tuser  out  1  high on pixel (0,0) of a frame (SOF).
- pix_tlast  out  1  high on the last pixel of each line (x = IMG_WIDTH-1).
- frame_done  out  1  one-cycle pulse when the last pixel of a frame transfers.
- frame_count  out  CNT_W  completed frames since reset; wraps at 2^CNT_W.

Behaviour:
- Clock and reset: one clock, ap_clk. Reset is quiesce, which is synchronous and active-high.
- Reset values: pix_tvalid=0, pix_tdata=0, pix_tuser=0, pix_tlast=0, frame_done=0, frame_count=0, from_host_pix_tready=0 on the reset cycle, 1 on the first cycle after. Internally x=0, y=0, byte_idx=0, holding register empty.
- Holding register:
  - 32-bit word plus byte_idx (0..3) plus full flag.
  - pix_tvalid = full. pix_tdata = word byte selected by byte_idx.
- Pixel transfer: out_fire = pix_tvalid && pix_tready.
  - On out_fire with byte_idx<3: byte_idx increments.
  - On out_fire with byte_idx=3: register empties, unless refilled in the same cycle.
- Input accept: from_host_pix_tready = !full || (out_fire_pending_last), where out_fire_pending_last = pix_tready && byte_idx==3. This lets the next word load in the same cycle the last byte leaves, with no bubble.
  - tready must not depend combinationally on from_host_pix_tvalid.
  - In_fire loads the word, sets full=1 and byte_idx=0.
- Latency: word accepted in cycle N drives byte 0 at cycle N+1. Sustained throughput is 1 pixel/cycle, i.e. one input word every 4 cycles when pix_tready stays high.
- Position counters advance only on out_fire.
  - x increments; at x=IMG_WIDTH-1, x→0 and y increments.
  - At y=IMG_HEIGHT-1 with x=IMG_WIDTH-1, y→0.
  - pix_tuser = (x==0 && y==0). pix_tlast = (x==IMG_WIDTH-1). Both are combinational from the counters, qualified by pix_tvalid (0 when !pix_tvalid).
- frame_done is registered. It is 1 in the cycle after out_fire of pixel (IMG_WIDTH-1, IMG_HEIGHT-1). frame_count increments in that same cycle.
- Backpressure: with pix_tready=0, pix_tdata/tuser/tlast/tvalid hold stable and no counter changes.
- Input stall: with tvalid=0 after the register drains, pix_tvalid=0. Counters hold, and a frame resumes mid-line with no realignment.
- Word alignment: IMG_WIDTH%4==0, so a word never straddles a line. byte_idx==0 coincides with x%4==0 at all times; verification asserts this invariant.
- Reset mid-frame:
  - Partial word discarded; x, y, byte_idx cleared; next accepted word is treated as pixel (0,0).
  - frame_count clears; frame_done is not pulsed.
- Simultaneous load on last-byte drain plus end of frame: new word's byte 0 is pixel (0,0) of the next frame with pix_tuser=1. frame_done pulses exactly once.

Decomposition:
- Shared package hog_pkg:
  - PIX_W=8, XB_W=32, PIX_PER_WORD=4.
  - Default HOG window constants WIN_W=64, WIN_H=128, reused by the gradient and histogram stages.
- One natural sub-module: hog_frame_pos. It holds the x/y counters with enable, emits sof/eol/eof, and is reusable by downstream stages.
- The holding register and handshake stay in the top module.

Test Plan:
- Continuous stream, pix_tready=1, IMG_WIDTH=8, IMG_HEIGHT=2, words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C → pixels 0x00..0x0F on consecutive cycles. tuser only on 0x00, tlast on 0x07 and 0x0F, frame_done one cycle after 0x0F, frame_count=1, tready high 1 cycle in 4.
- Random pix_tready (50%) over 3 frames of 64x128 → output sequence byte-identical to input order. tdata/tuser/tlast stable while stalled. frame_count=3.
- Random from_host_pix_tvalid gaps → no duplicated or dropped pixels. pix_tvalid=0 during gaps once drained. tuser/tlast positions unchanged.
- Assert quiesce after 37 pixels of a frame, deassert, send a fresh frame → first output pixel has tuser=1. frame_count=0 before the new frame, 1 after. No frame_done during reset.
- Back-to-back frames with pix_tready=1 → last pixel of frame k and pixel (0,0) of frame k+1 on adjacent cycles. No bubble at the boundary.
- frame_count wrap with CNT_W=2, 5 frames of 8x1 → frame_count sequence 1,2,3,0,1.
